// File: rtl/fu_pkt_pkg.sv
// Shared definitions for the function-unit packet transmitter:
// packet layout, FSM state type and the IFMAP packet builder.
package fu_pkt_pkg;

  localparam int PKT_W   = 26;
  localparam int CLR_BIT = 25;
  localparam int FLT_BIT = 24;

  // Payload bit positions of the three window spikes, window position 0 first.
  localparam int SPK_POS [3] = '{16, 8, 0};

  typedef logic [PKT_W-1:0] fu_pkt_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FILTER,
    S_IFMAP,
    S_DONE
  } fu_tx_state_t;

  // Spread a 3-bit window onto the spike positions; every other bit stays zero.
  function automatic fu_pkt_t ifmap_pkt(input logic [2:0] win);
    fu_pkt_t pkt;
    pkt = '0;
    for (int i = 0; i < 3; i++) begin
      pkt[SPK_POS[i]] = win[i];
    end
    return pkt;
  endfunction

endpackage

// File: rtl/fu_ifmap_shreg.sv
// Captured ifmap row that slides one position per IFMAP handshake.
// The low three bits are the current window; a window counter flags the
// last window so the sender knows when to finish.
module fu_ifmap_shreg #(
  parameter int IFMAP_LEN = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 shift_i,
  input  logic [IFMAP_LEN-1:0] row_i,
  output logic [2:0]           win_o,
  output logic                 last_o
);

  localparam int CNT_W = (IFMAP_LEN > 4) ? $clog2(IFMAP_LEN) : 2;

  logic [IFMAP_LEN-1:0] row_q;
  logic [CNT_W-1:0]     cnt_q;

  // Load on start acceptance, otherwise shift right and count on each window sent.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      row_q <= row_i;
      cnt_q <= '0;
    end else if (shift_i) begin
      row_q <= row_q >> 1;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign win_o  = row_q[2:0];
  assign last_o = (cnt_q == CNT_W'(IFMAP_LEN - 3));

endmodule

// File: rtl/fu_packet_sender.sv
// Packet transmitter feeding a function unit: optional CLEAR, then FILTER,
// then one IFMAP packet per 3-wide window of the captured spike row.
// Valid/ready channel; outputs are decoded from registered state only.
module fu_packet_sender
  import fu_pkt_pkg::*;
#(
  parameter int IFMAP_LEN  = 5,
  parameter bit SEND_CLEAR = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [23:0]          filter_w,
  input  logic [IFMAP_LEN-1:0] ifmap_row,
  output logic                 busy,
  output logic                 done,
  output fu_pkt_t              pkt_data,
  output logic                 pkt_valid,
  input  logic                 pkt_ready
);

  fu_tx_state_t state_q, state_d;
  logic [23:0]  filter_q;
  logic         accept;
  logic         hs;
  logic         shift;
  logic [2:0]   win;
  logic         last_win;

  // start is only honoured from IDLE; anything arriving while busy is dropped.
  assign accept = (state_q == S_IDLE) && start;
  assign hs     = pkt_valid && pkt_ready;
  assign shift  = (state_q == S_IFMAP) && hs;

  fu_ifmap_shreg #(
    .IFMAP_LEN(IFMAP_LEN)
  ) u_shreg (
    .clk    (clk),
    .rst    (rst),
    .load_i (accept),
    .shift_i(shift),
    .row_i  (ifmap_row),
    .win_o  (win),
    .last_o (last_win)
  );

  // State register; reset abandons any sequence in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Weights are frozen at start acceptance so later input changes cannot leak in.
  always_ff @(posedge clk) begin
    if (rst) begin
      filter_q <= '0;
    end else if (accept) begin
      filter_q <= filter_w;
    end
  end

  // Next state: advance only on a handshake so valid never drops unaccepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = SEND_CLEAR ? S_CLEAR : S_FILTER;
        end
      end
      S_CLEAR: begin
        if (hs) state_d = S_FILTER;
      end
      S_FILTER: begin
        if (hs) state_d = S_IFMAP;
      end
      S_IFMAP: begin
        if (hs && last_win) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs: packet contents depend only on state and captured data, so they hold while stalled.
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = 1'b0;
    pkt_valid = 1'b0;
    pkt_data  = '0;
    case (state_q)
      S_CLEAR: begin
        pkt_valid         = 1'b1;
        pkt_data[CLR_BIT] = 1'b1;
      end
      S_FILTER: begin
        pkt_valid         = 1'b1;
        pkt_data[FLT_BIT] = 1'b1;
        pkt_data[23:0]    = filter_q;
      end
      S_IFMAP: begin
        pkt_valid = 1'b1;
        pkt_data  = ifmap_pkt(win);
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        done = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fu_packet_sender.sv
// Bench for fu_packet_sender: one instance with CLEAR enabled (A), one without (B).
// Expected packets come from literal sequences or from a window-by-window model.
module tb_fu_packet_sender;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic        pkt_ready;
  logic [23:0] filter_w;
  logic [4:0]  ifmap_row;

  logic        busy_a, done_a, valid_a;
  logic [25:0] data_a;
  logic        busy_b, done_b, valid_b;
  logic [25:0] data_b;

  int          errors = 0;
  int          checks = 0;
  bit          sel = 1'b0;
  logic [25:0] exp_q[$];

  logic        obs_busy, obs_done, obs_valid;
  logic [25:0] obs_data;

  always #5 clk = ~clk;

  fu_packet_sender #(.IFMAP_LEN(5), .SEND_CLEAR(1'b1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .filter_w(filter_w), .ifmap_row(ifmap_row),
    .busy(busy_a), .done(done_a), .pkt_data(data_a), .pkt_valid(valid_a), .pkt_ready(pkt_ready)
  );

  fu_packet_sender #(.IFMAP_LEN(5), .SEND_CLEAR(1'b0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .filter_w(filter_w), .ifmap_row(ifmap_row),
    .busy(busy_b), .done(done_b), .pkt_data(data_b), .pkt_valid(valid_b), .pkt_ready(pkt_ready)
  );

  assign obs_busy  = sel ? busy_b  : busy_a;
  assign obs_done  = sel ? done_b  : done_a;
  assign obs_valid = sel ? valid_b : valid_a;
  assign obs_data  = sel ? data_b  : data_a;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_start(input bit v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  // Reference: optional CLEAR, FILTER, then one packet per window position k.
  task automatic build_exp(input bit sc, input logic [23:0] f, input logic [4:0] row);
    logic [25:0] p;
    exp_q.delete();
    if (sc) exp_q.push_back(26'h2000000);
    exp_q.push_back({2'b01, f});
    for (int k = 0; k <= 5 - 3; k++) begin
      p = '0;
      p[16] = row[k];
      p[8]  = row[k+1];
      p[0]  = row[k+2];
      exp_q.push_back(p);
    end
  endtask

  // mode 0: ready high, 1: ready low 3 cycles per packet, 2: random ready.
  // poke: re-pulse start mid-sequence and in the done cycle with altered inputs.
  task automatic run_seq(input string name, input int mode, input bit poke);
    int          npk, c, hs, done_cnt, done_c, busy_cnt, stall;
    bit          prev_stall, r;
    logic [25:0] prev_data, e;
    npk = exp_q.size();
    c = 0; hs = 0; done_cnt = 0; done_c = 0; busy_cnt = 0; stall = 0;
    prev_stall = 1'b0; prev_data = '0;
    @(negedge clk);
    set_start(1'b1);
    pkt_ready = (mode == 0);
    while (c < 300) begin
      @(negedge clk);
      c++;
      set_start(1'b0);
      if (done_cnt > 0 && c > done_c) begin
        check({name, " idle_busy"}, obs_busy, 0);
        check({name, " idle_valid"}, obs_valid, 0);
        break;
      end
      if (poke && c == 3) begin
        set_start(1'b1);
        filter_w  = ~filter_w;
        ifmap_row = ~ifmap_row;
      end
      if (obs_busy) busy_cnt++;
      if (prev_stall) begin
        check({name, " stall_valid"}, obs_valid, 1);
        check({name, " stall_data"}, obs_data, prev_data);
      end
      if (obs_done) begin
        done_cnt++;
        done_c = c;
        if (poke) set_start(1'b1);
      end
      if (mode == 0) r = 1'b1;
      else if (mode == 1) begin
        if (obs_valid) begin
          r = (stall == 3);
          stall = r ? 0 : stall + 1;
        end else r = 1'b1;
      end else r = 1'($urandom_range(0, 1));
      pkt_ready = r;
      if (obs_valid && r) begin
        hs++;
        if (exp_q.size() == 0) begin
          check({name, " extra_pkt"}, hs, npk);
        end else begin
          e = exp_q.pop_front();
          check({name, " pkt"}, obs_data, e);
          $display("%s hs=%0d cyc=%0d data=0x%07h", name, hs, c, obs_data);
        end
      end
      prev_stall = obs_valid && !r;
      prev_data  = obs_data;
    end
    set_start(1'b0);
    pkt_ready = 1'b1;
    check({name, " done_count"}, done_cnt, 1);
    check({name, " handshakes"}, hs, npk);
    check({name, " busy_span"}, busy_cnt, done_c);
    if (mode == 0) begin
      check({name, " done_cycle"}, done_c, npk + 1);
      check({name, " busy_cycles"}, busy_cnt, npk + 1);
    end
  endtask

  initial begin
    int dcnt;
    bit sc;
    logic [23:0] f;
    logic [4:0]  row;

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; pkt_ready = 1'b1;
    filter_w = '0; ifmap_row = '0;
    repeat (2) @(negedge clk);
    check("rst busy_a", busy_a, 0);
    check("rst done_a", done_a, 0);
    check("rst valid_a", valid_a, 0);
    check("rst data_a", data_a, 0);
    check("rst busy_b", busy_b, 0);
    check("rst valid_b", valid_b, 0);
    check("rst data_b", data_b, 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic sequence, ready tied high.
    sel = 1'b0; filter_w = 24'h0E0508; ifmap_row = 5'b00101;
    exp_q = '{26'h2000000, 26'h10E0508, 26'h0010001, 26'h0000100, 26'h0010000};
    run_seq("t1", 0, 1'b0);

    // Same stimulus with 3-cycle stalls per packet.
    exp_q = '{26'h2000000, 26'h10E0508, 26'h0010001, 26'h0000100, 26'h0010000};
    run_seq("t2", 1, 1'b0);

    // No CLEAR packet.
    sel = 1'b1; filter_w = 24'hFF0001; ifmap_row = 5'b11111;
    exp_q = '{26'h1FF0001, 26'h0010101, 26'h0010101, 26'h0010101};
    run_seq("t3", 0, 1'b0);

    // Reset during the second IFMAP packet.
    sel = 1'b0; filter_w = 24'h0E0508; ifmap_row = 5'b00101; pkt_ready = 1'b1;
    @(negedge clk); start_a = 1'b1;
    repeat (4) begin @(negedge clk); start_a = 1'b0; end
    check("t4 pre_rst_data", data_a, 26'h0000100);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t4 rst_valid", valid_a, 0);
    check("t4 rst_busy", busy_a, 0);
    dcnt = 0;
    repeat (5) begin @(negedge clk); if (done_a) dcnt++; end
    check("t4 no_done", dcnt, 0);
    exp_q = '{26'h2000000, 26'h10E0508, 26'h0010001, 26'h0000100, 26'h0010000};
    run_seq("t4b", 0, 1'b0);

    // start together with rst: reset wins.
    @(negedge clk); start_a = 1'b1; rst = 1'b1;
    @(negedge clk); start_a = 1'b0; rst = 1'b0;
    check("rst_start busy", busy_a, 0);
    @(negedge clk);
    check("rst_start busy2", busy_a, 0);

    // start re-pulsed mid-sequence and in the done cycle with new inputs.
    filter_w = 24'h0E0508; ifmap_row = 5'b00101;
    build_exp(1'b1, filter_w, ifmap_row);
    run_seq("t5", 2, 1'b1);

    // Randomized sequences on both variants.
    for (int i = 0; i < 12; i++) begin
      sel = 1'($urandom_range(0, 1));
      sc  = !sel;
      f   = 24'($urandom);
      row = 5'($urandom);
      filter_w = f; ifmap_row = row;
      build_exp(sc, f, row);
      run_seq(sel ? "rndB" : "rndA", 2, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
